// File: rtl/uart_tx_arbiter_pkg.sv
//==============================================================================
// Module      : uart_tx_arbiter_pkg
// Description : Shared state encodings and defaults for the UART TX arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SEND = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_t;

    // Protocol no-op byte, also the resting value of the SendData producers.
    localparam logic [7:0] C_IDLE_BYTE = 8'h00;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_cycle_counter.sv
//==============================================================================
// Module      : cycle_counter
// Description : Saturating up-counter with clear, enable and terminal compare.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cycle_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_terminal,
    output logic             o_at_terminal
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_at_terminal = (r_count == i_terminal);

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module      : uart_tx_arbiter
// Description : Single-owner arbiter between manual/script byte sources and
//               the UART transmit port, with inter-byte gap and send timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE      = C_IDLE_BYTE,
    parameter int         GAP_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 4096
) (
    input  logic       uart_clk,
    input  logic       reset,
    input  logic       sel_script,
    input  logic [7:0] man_bits,
    input  logic       man_valid,
    output logic       man_ready,
    input  logic [7:0] scr_bits,
    input  logic       scr_valid,
    output logic       scr_ready,
    output logic [7:0] tx_bits,
    input  logic       tx_done,
    output logic       busy,
    output logic       timeout_pulse
);

    localparam int              C_CNT_MAX  = max_int(TIMEOUT_CYCLES, GAP_CYCLES);
    localparam int              CW         = $clog2(C_CNT_MAX + 1);
    localparam logic [CW-1:0]   C_TO_TERM  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]   C_GAP_TERM = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic [7:0]    r_hold;
    logic          r_timeout;

    logic          w_sel_valid;
    logic [7:0]    w_sel_bits;
    logic          w_accept;
    logic          w_cnt_clear;
    logic          w_cnt_en;
    logic          w_timeout;
    logic [CW-1:0] w_terminal;
    logic          w_at_terminal;

    assign w_sel_valid = sel_script ? scr_valid : man_valid;
    assign w_sel_bits  = sel_script ? scr_bits  : man_bits;

    cycle_counter #(
        .WIDTH (CW)
    ) u_cycle_counter (
        .clk           (uart_clk),
        .rst           (reset),
        .i_clear       (w_cnt_clear),
        .i_en          (w_cnt_en),
        .i_terminal    (w_terminal),
        .o_at_terminal (w_at_terminal)
    );

    always_ff @(posedge uart_clk) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_hold    <= IDLE_BYTE;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_timeout <= w_timeout;
            if (w_accept) begin
                r_hold <= w_sel_bits;
            end
        end
    end

    // One counter serves both SEND (timeout) and GAP; its terminal follows the state.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_cnt_clear  = 1'b0;
        w_cnt_en     = 1'b0;
        w_timeout    = 1'b0;
        w_terminal   = C_TO_TERM;
        case (r_state)
            ARB_IDLE: begin
                if (w_sel_valid) begin
                    w_accept     = 1'b1;
                    w_cnt_clear  = 1'b1;
                    w_state_next = ARB_SEND;
                end
            end
            ARB_SEND: begin
                w_cnt_en = 1'b1;
                if (tx_done) begin
                    w_cnt_clear  = 1'b1;
                    w_state_next = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
                end else if (w_at_terminal) begin
                    w_timeout    = 1'b1;
                    w_state_next = ARB_IDLE;
                end
            end
            ARB_GAP: begin
                w_terminal = C_GAP_TERM;
                w_cnt_en   = 1'b1;
                if (w_at_terminal) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    assign man_ready     = (r_state == ARB_IDLE) && !reset && !sel_script;
    assign scr_ready     = (r_state == ARB_IDLE) && !reset &&  sel_script;
    assign tx_bits       = (r_state == ARB_SEND) ? r_hold : IDLE_BYTE;
    assign busy          = (r_state != ARB_IDLE);
    assign timeout_pulse = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//==============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench; DUT A (gap 16, timeout 8), DUT B (gap 0).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [7:0] man_bits;
    logic       man_valid;
    logic [7:0] scr_bits;
    logic       scr_valid;
    logic       tx_done;

    logic       a_man_ready, a_scr_ready, a_busy, a_pulse;
    logic [7:0] a_tx;
    logic       b_man_ready, b_scr_ready, b_busy, b_pulse;
    logic [7:0] b_tx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .IDLE_BYTE      (8'h00),
        .GAP_CYCLES     (16),
        .TIMEOUT_CYCLES (8)
    ) dut_a (
        .uart_clk      (clk),
        .reset         (rst),
        .sel_script    (sel),
        .man_bits      (man_bits),
        .man_valid     (man_valid),
        .man_ready     (a_man_ready),
        .scr_bits      (scr_bits),
        .scr_valid     (scr_valid),
        .scr_ready     (a_scr_ready),
        .tx_bits       (a_tx),
        .tx_done       (tx_done),
        .busy          (a_busy),
        .timeout_pulse (a_pulse)
    );

    uart_tx_arbiter #(
        .IDLE_BYTE      (8'h00),
        .GAP_CYCLES     (0),
        .TIMEOUT_CYCLES (20)
    ) dut_b (
        .uart_clk      (clk),
        .reset         (rst),
        .sel_script    (sel),
        .man_bits      (man_bits),
        .man_valid     (man_valid),
        .man_ready     (b_man_ready),
        .scr_bits      (scr_bits),
        .scr_valid     (scr_valid),
        .scr_ready     (b_scr_ready),
        .tx_bits       (b_tx),
        .tx_done       (tx_done),
        .busy          (b_busy),
        .timeout_pulse (b_pulse)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        sel       = 1'b0;
        man_bits  = 8'h00;
        man_valid = 1'b0;
        scr_bits  = 8'h00;
        scr_valid = 1'b0;
        tx_done   = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        idle_inputs();
        sel = 1'b1; man_valid = 1'b1; scr_valid = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({a_man_ready, a_scr_ready, a_busy, a_pulse, a_tx} !== 12'h000) begin
            errors++;
            $display("FAIL reset_a got mr=%b sr=%b busy=%b pulse=%b tx=%h exp all zero",
                     a_man_ready, a_scr_ready, a_busy, a_pulse, a_tx);
        end
        checks++;
        if ({b_man_ready, b_scr_ready, b_busy, b_pulse, b_tx} !== 12'h000) begin
            errors++;
            $display("FAIL reset_b got mr=%b sr=%b busy=%b pulse=%b tx=%h exp all zero",
                     b_man_ready, b_scr_ready, b_busy, b_pulse, b_tx);
        end
        rst = 1'b0;
        idle_inputs();
        #1;
    endtask

    task automatic test_manual_send;
        do_reset();
        man_bits = 8'h5A; man_valid = 1'b1;
        #1;
        checks++;
        if ({a_man_ready, a_scr_ready} !== 2'b10) begin
            errors++;
            $display("FAIL manual_ready got mr=%b sr=%b exp mr=1 sr=0", a_man_ready, a_scr_ready);
        end
        tick();
        man_valid = 1'b0;
        checks++;
        if (a_tx !== 8'h5A || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL manual_tx got tx=%h busy=%b exp tx=5a busy=1", a_tx, a_busy);
        end
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checks++;
        if (a_tx !== 8'h00 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL manual_gap_tx got tx=%h busy=%b exp tx=00 busy=1", a_tx, a_busy);
        end
        for (int i = 0; i <= 16; i++) begin
            checks++;
            if (a_man_ready !== (i == 16)) begin
                errors++;
                $display("FAIL manual_gap_ready cycle=%0d got %b exp %b", i, a_man_ready, (i == 16));
            end
            if (i < 16) tick();
        end
    endtask

    task automatic test_source_isolation;
        do_reset();
        sel = 1'b1;
        man_bits = 8'h11; man_valid = 1'b1;
        scr_bits = 8'h22; scr_valid = 1'b1;
        #1;
        checks++;
        if ({a_man_ready, a_scr_ready} !== 2'b01) begin
            errors++;
            $display("FAIL iso_ready got mr=%b sr=%b exp mr=0 sr=1", a_man_ready, a_scr_ready);
        end
        tick();
        man_valid = 1'b0; scr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = ~sel;
            #1;
            checks++;
            if (a_tx !== 8'h22 || a_man_ready !== 1'b0 || a_scr_ready !== 1'b0) begin
                errors++;
                $display("FAIL iso_hold cycle=%0d got tx=%h mr=%b sr=%b exp tx=22 ready=0",
                         i, a_tx, a_man_ready, a_scr_ready);
            end
            if (i < 3) tick();
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checks++;
        if (a_tx !== 8'h00) begin
            errors++;
            $display("FAIL iso_done_tx got %h exp 00", a_tx);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        man_bits = 8'hC3; man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (a_tx !== 8'hC3 || a_busy !== 1'b1 || a_pulse !== 1'b0) begin
                errors++;
                $display("FAIL timeout_send cycle=%0d got tx=%h busy=%b pulse=%b exp tx=c3 busy=1 pulse=0",
                         i, a_tx, a_busy, a_pulse);
            end
            tick();
        end
        checks++;
        if (a_pulse !== 1'b1 || a_busy !== 1'b0 || a_tx !== 8'h00) begin
            errors++;
            $display("FAIL timeout_fire got pulse=%b busy=%b tx=%h exp pulse=1 busy=0 tx=00",
                     a_pulse, a_busy, a_tx);
        end
        tick();
        checks++;
        if (a_pulse !== 1'b0) begin
            errors++;
            $display("FAIL timeout_width got pulse=%b exp 0", a_pulse);
        end
    endtask

    task automatic test_timeout_tie;
        do_reset();
        man_bits = 8'h77; man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (a_pulse !== 1'b0 || a_busy !== 1'b1 || a_tx !== 8'h00) begin
                errors++;
                $display("FAIL tie cycle=%0d got pulse=%b busy=%b tx=%h exp pulse=0 busy=1 tx=00",
                         i, a_pulse, a_busy, a_tx);
            end
            tick();
        end
    endtask

    task automatic test_zero_gap;
        do_reset();
        man_bits = 8'h01; man_valid = 1'b1;
        tick();
        man_bits = 8'h02;
        checks++;
        if (b_tx !== 8'h01 || b_man_ready !== 1'b0) begin
            errors++;
            $display("FAIL zgap_first got tx=%h mr=%b exp tx=01 mr=0", b_tx, b_man_ready);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checks++;
        if (b_tx !== 8'h00 || b_busy !== 1'b0 || b_man_ready !== 1'b1) begin
            errors++;
            $display("FAIL zgap_idle got tx=%h busy=%b mr=%b exp tx=00 busy=0 mr=1", b_tx, b_busy, b_man_ready);
        end
        tick();
        man_valid = 1'b0;
        checks++;
        if (b_tx !== 8'h02 || b_busy !== 1'b1) begin
            errors++;
            $display("FAIL zgap_second got tx=%h busy=%b exp tx=02 busy=1", b_tx, b_busy);
        end
        tx_done = 1'b1;
        tick();
        tick();
        tx_done = 1'b0;
        checks++;
        if (b_tx !== 8'h00 || b_busy !== 1'b0 || b_pulse !== 1'b0) begin
            errors++;
            $display("FAIL zgap_idle_done got tx=%h busy=%b pulse=%b exp 00/0/0", b_tx, b_busy, b_pulse);
        end
    endtask

    task automatic test_reset_mid_send;
        do_reset();
        man_bits = 8'hAB; man_valid = 1'b1;
        tick();
        man_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (a_tx !== 8'h00 || a_busy !== 1'b0 || a_man_ready !== 1'b0 || a_pulse !== 1'b0) begin
            errors++;
            $display("FAIL rst_send got tx=%h busy=%b mr=%b pulse=%b exp 00/0/0/0",
                     a_tx, a_busy, a_man_ready, a_pulse);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (a_pulse !== 1'b0 || a_busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_after cycle=%0d got pulse=%b busy=%b exp 0/0", i, a_pulse, a_busy);
            end
            tick();
        end
        man_bits = 8'h3C; man_valid = 1'b1;
        #1;
        checks++;
        if (a_man_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_reaccept_ready got %b exp 1", a_man_ready);
        end
        tick();
        man_valid = 1'b0;
        checks++;
        if (a_tx !== 8'h3C) begin
            errors++;
            $display("FAIL rst_reaccept_tx got %h exp 3c", a_tx);
        end
    endtask

    // Transaction-level model: a held byte ages until done or timeout, then a gap countdown.
    task automatic test_random;
        int         gap_len [2];
        int         to_len  [2];
        bit         m_held  [2];
        logic [7:0] m_byte  [2];
        int         m_age   [2];
        int         m_gap   [2];
        bit         m_pulse [2];
        logic [11:0] exp_v;
        logic [11:0] obs_v;
        bit          e_idle;
        gap_len[0] = 16; gap_len[1] = 0;
        to_len[0]  = 8;  to_len[1]  = 20;
        do_reset();
        for (int d = 0; d < 2; d++) begin
            m_held[d] = 1'b0; m_byte[d] = 8'h00; m_age[d] = 0; m_gap[d] = 0; m_pulse[d] = 1'b0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst       = ($urandom_range(0, 79) == 0);
            sel       = 1'($urandom_range(0, 1));
            man_valid = 1'($urandom_range(0, 1));
            scr_valid = 1'($urandom_range(0, 1));
            man_bits  = 8'($urandom);
            scr_bits  = 8'($urandom);
            tx_done   = ($urandom_range(0, 5) == 0);
            #1;
            for (int d = 0; d < 2; d++) begin
                e_idle = !m_held[d] && (m_gap[d] == 0);
                exp_v  = {e_idle && !rst && !sel, e_idle && !rst && sel, !e_idle, m_pulse[d],
                          m_held[d] ? m_byte[d] : 8'h00};
                obs_v  = (d == 0) ? {a_man_ready, a_scr_ready, a_busy, a_pulse, a_tx}
                                  : {b_man_ready, b_scr_ready, b_busy, b_pulse, b_tx};
                checks++;
                if (obs_v !== exp_v) begin
                    errors++;
                    $display("FAIL random dut=%0d cyc=%0d got {mr,sr,busy,pulse,tx}=%h exp %h",
                             d, cyc, obs_v, exp_v);
                end
                m_pulse[d] = 1'b0;
                if (rst) begin
                    m_held[d] = 1'b0; m_gap[d] = 0;
                end else if (m_held[d]) begin
                    m_age[d]++;
                    if (tx_done) begin
                        m_held[d] = 1'b0;
                        m_gap[d]  = gap_len[d];
                    end else if (m_age[d] == to_len[d]) begin
                        m_held[d]  = 1'b0;
                        m_pulse[d] = 1'b1;
                    end
                end else if (m_gap[d] > 0) begin
                    m_gap[d]--;
                end else if (sel ? scr_valid : man_valid) begin
                    m_held[d] = 1'b1;
                    m_byte[d] = sel ? scr_bits : man_bits;
                    m_age[d]  = 0;
                end
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_manual_send();
        test_source_isolation();
        test_timeout();
        test_timeout_tie();
        test_zero_gap();
        test_reset_mid_send();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
